// File: rtl/midi_pkg.sv
// Shared constants, FSM encodings and byte classification types for the MIDI parser.
package midi_pkg;

    // Parser FSM encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_D1 = 3'd1;
    localparam logic [2:0] ST_WAIT_D2 = 3'd2;
    localparam logic [2:0] ST_SKIP1   = 3'd3;
    localparam logic [2:0] ST_SKIP2   = 3'd4;
    localparam logic [2:0] ST_SYSEX   = 3'd5;

    // Status-class constants
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [7:0] SYSEX    = 8'hF0;
    localparam logic [7:0] EOX      = 8'hF7;
    localparam logic [7:0] RT_MIN   = 8'hF8;

    typedef enum logic [2:0] {
        CLS_DATA,
        CLS_VOICE,
        CLS_COMMON,
        CLS_SYSEX,
        CLS_REALTIME
    } byte_class_t;

    // Number of data bytes that follow a channel-voice status nibble
    function automatic logic [1:0] msg_len(input logic [3:0] status_hi);
        logic [1:0] len;
        case (status_hi)
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
            4'hC, 4'hD:                   len = 2'd1;
            default:                      len = 2'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/midi_msg_parser_if.sv
// Byte-input and note-event bus of the MIDI message parser.
interface midi_msg_parser_if;
    logic [7:0] BYTE_IN;
    logic       BYTE_VALID;
    logic       FRAME_ERR;
    logic       EV_VALID;
    logic       EV_NOTE_ON;
    logic [3:0] EV_CHAN;
    logic [6:0] EV_NOTE;
    logic [6:0] EV_VEL;

    // Byte source and event sink side
    modport master (
        output BYTE_IN, BYTE_VALID, FRAME_ERR,
        input  EV_VALID, EV_NOTE_ON, EV_CHAN, EV_NOTE, EV_VEL
    );

    // Parser side
    modport slave (
        input  BYTE_IN, BYTE_VALID, FRAME_ERR,
        output EV_VALID, EV_NOTE_ON, EV_CHAN, EV_NOTE, EV_VEL
    );
endinterface

// File: rtl/midi_status_decode.sv
// Combinational classifier for one received MIDI byte.
module midi_status_decode
    import midi_pkg::*;
(
    input  logic [7:0]  data_byte,
    output byte_class_t byte_class,
    output logic [1:0]  data_cnt
);

    // Real-time is tested before sysex/common since it shares the Fx nibble
    always_comb begin
        byte_class = CLS_DATA;
        data_cnt   = 2'd0;
        if (!data_byte[7]) begin
            byte_class = CLS_DATA;
        end else if (data_byte >= RT_MIN) begin
            byte_class = CLS_REALTIME;
        end else if (data_byte == SYSEX) begin
            byte_class = CLS_SYSEX;
        end else if (data_byte[7:4] == 4'hF) begin
            byte_class = CLS_COMMON;
        end else begin
            byte_class = CLS_VOICE;
            data_cnt   = msg_len(data_byte[7:4]);
        end
    end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: extracts note-on/off events with running status,
// skips other channel messages and sysex, counts framing errors.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int unsigned OMNI    = 1,
    parameter logic [3:0]  CHANNEL = 4'h0
) (
    input  logic               CLK,
    input  logic               RESET,
    midi_msg_parser_if.slave   bus,
    output logic [7:0]         LED,
    output logic [7:0]         ERR_COUNT
);

    logic [2:0] state_q, state_d;
    logic [7:0] rs_q, rs_d;       // running status, 8'h00 means none
    logic [6:0] note_q, note_d;
    logic       emit;

    logic       ev_valid_q, ev_note_on_q;
    logic [3:0] ev_chan_q;
    logic [6:0] ev_note_q, ev_vel_q;
    logic [7:0] led_q, err_q;

    byte_class_t byte_class;
    logic [1:0]  data_cnt;

    midi_status_decode u_decode (
        .data_byte  (bus.BYTE_IN),
        .byte_class (byte_class),
        .data_cnt   (data_cnt)
    );

    logic       rs_is_note;
    logic       chan_ok;
    logic       is_on;
    logic [6:0] vel;

    assign rs_is_note = (rs_q[7:4] == NOTE_OFF) || (rs_q[7:4] == NOTE_ON);
    assign chan_ok    = (OMNI != 0) || (rs_q[3:0] == CHANNEL);
    assign vel        = bus.BYTE_IN[6:0];
    // Note-on with zero velocity is a note-off
    assign is_on      = (rs_q[7:4] == NOTE_ON) && (vel != 7'd0);

    // Next-state decode of the parser FSM and running status
    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        note_d  = note_q;
        emit    = 1'b0;
        if (bus.BYTE_VALID) begin
            if (bus.FRAME_ERR) begin
                state_d = rs_is_note ? ST_WAIT_D1 : ST_IDLE;
            end else begin
                case (byte_class)
                    CLS_REALTIME: ;
                    CLS_VOICE: begin
                        rs_d = bus.BYTE_IN;
                        if (bus.BYTE_IN[7:4] == NOTE_OFF || bus.BYTE_IN[7:4] == NOTE_ON) begin
                            state_d = ST_WAIT_D1;
                        end else if (data_cnt == 2'd1) begin
                            state_d = ST_SKIP1;
                        end else begin
                            state_d = ST_SKIP2;
                        end
                    end
                    CLS_SYSEX: begin
                        rs_d    = 8'h00;
                        state_d = ST_SYSEX;
                    end
                    CLS_COMMON: begin
                        // Includes EOX terminating a sysex dump
                        rs_d    = 8'h00;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        case (state_q)
                            ST_WAIT_D1: begin
                                note_d  = bus.BYTE_IN[6:0];
                                state_d = ST_WAIT_D2;
                            end
                            ST_WAIT_D2: begin
                                emit    = chan_ok;
                                state_d = ST_WAIT_D1;
                            end
                            ST_SKIP2: state_d = ST_SKIP1;
                            ST_SKIP1: state_d = (msg_len(rs_q[7:4]) == 2'd1) ? ST_SKIP1 : ST_SKIP2;
                            default: ;
                        endcase
                    end
                endcase
            end
        end
    end

    // FSM, running status and stored note
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            rs_q    <= 8'h00;
            note_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            note_q  <= note_d;
        end
    end

    // Registered event outputs and LED; fields hold between events
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ev_valid_q   <= 1'b0;
            ev_note_on_q <= 1'b0;
            ev_chan_q    <= 4'h0;
            ev_note_q    <= 7'd0;
            ev_vel_q     <= 7'd0;
            led_q        <= 8'h00;
        end else begin
            ev_valid_q <= emit;
            if (emit) begin
                ev_note_on_q <= is_on;
                ev_chan_q    <= rs_q[3:0];
                ev_note_q    <= note_q;
                ev_vel_q     <= vel;
                if (is_on) begin
                    led_q <= {1'b1, note_q};
                end else if (led_q[7] && (led_q[6:0] == note_q)) begin
                    led_q <= 8'h00;
                end
            end
        end
    end

    // Saturating count of bytes dropped for bad framing
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err_q <= 8'h00;
        end else if (bus.BYTE_VALID && bus.FRAME_ERR && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.EV_VALID   = ev_valid_q;
    assign bus.EV_NOTE_ON = ev_note_on_q;
    assign bus.EV_CHAN    = ev_chan_q;
    assign bus.EV_NOTE    = ev_note_q;
    assign bus.EV_VEL     = ev_vel_q;
    assign LED            = led_q;
    assign ERR_COUNT      = err_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed self-checking bench for midi_msg_parser (omni instance plus a channel-2 instance).
module tb_midi_msg_parser;

    logic       clk;
    logic       rst_n;
    logic [7:0] led, led2;
    logic [7:0] err, err2;
    int         n_checks = 0;
    int         n_errors = 0;
    int         ev_cnt   = 0;
    int         ev_cnt2  = 0;

    midi_msg_parser_if bus ();
    midi_msg_parser_if bus2 ();

    midi_msg_parser dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .bus       (bus),
        .LED       (led),
        .ERR_COUNT (err)
    );

    midi_msg_parser #(.OMNI(0), .CHANNEL(4'h2)) dut2 (
        .CLK       (clk),
        .RESET     (rst_n),
        .bus       (bus2),
        .LED       (led2),
        .ERR_COUNT (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle with EV_VALID high, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.EV_VALID)  ev_cnt  <= ev_cnt + 1;
        if (bus2.EV_VALID) ev_cnt2 <= ev_cnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic fe);
        @(negedge clk);
        bus.BYTE_IN     = b;
        bus.FRAME_ERR   = fe;
        bus.BYTE_VALID  = 1'b1;
        bus2.BYTE_IN    = b;
        bus2.FRAME_ERR  = fe;
        bus2.BYTE_VALID = 1'b1;
    endtask

    // Drop the strobe with junk on the data lines, then settle one more cycle
    task automatic gap();
        @(negedge clk);
        bus.BYTE_VALID  = 1'b0;
        bus.BYTE_IN     = 8'hF0;
        bus.FRAME_ERR   = 1'b1;
        bus2.BYTE_VALID = 1'b0;
        bus2.BYTE_IN    = 8'hF0;
        bus2.FRAME_ERR  = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_ev(input string tag, input int cnt, input logic on, input logic [3:0] ch,
                            input logic [6:0] note, input logic [6:0] vel, input logic [7:0] l);
        check({tag, "_cnt"}, ev_cnt, cnt);
        check({tag, "_on"}, bus.EV_NOTE_ON, on);
        check({tag, "_chan"}, bus.EV_CHAN, ch);
        check({tag, "_note"}, bus.EV_NOTE, note);
        check({tag, "_vel"}, bus.EV_VEL, vel);
        check({tag, "_led"}, led, l);
        check({tag, "_valid_low"}, bus.EV_VALID, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.BYTE_VALID = 1'b0;  bus.BYTE_IN = 8'h00;  bus.FRAME_ERR = 1'b0;
        bus2.BYTE_VALID = 1'b0; bus2.BYTE_IN = 8'h00; bus2.FRAME_ERR = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_ev("reset", 0, 1'b0, 4'h0, 7'h00, 7'h00, 8'h00);
        check("reset_err", err, 8'h00);

        // Basic note-on
        send(8'h90, 0); send(8'h3C, 0); send(8'h64, 0); gap();
        check_ev("t1", 1, 1'b1, 4'h0, 7'h3C, 7'h64, 8'hBC);

        // Running status: note-on then velocity-0 note-off
        send(8'h91, 0); send(8'h40, 0); send(8'h7F, 0); gap();
        check_ev("t2a", 2, 1'b1, 4'h1, 7'h40, 7'h7F, 8'hC0);
        send(8'h40, 0); send(8'h00, 0); gap();
        check_ev("t2b", 3, 1'b0, 4'h1, 7'h40, 7'h00, 8'h00);

        // Real-time byte inside a message
        send(8'h90, 0); send(8'h3C, 0); send(8'hF8, 0); send(8'h64, 0); gap();
        check_ev("t3", 4, 1'b1, 4'h0, 7'h3C, 7'h64, 8'hBC);

        // Control change skipped, including a running-status repeat
        send(8'hB0, 0); send(8'h07, 0); send(8'h7F, 0); send(8'h07, 0); send(8'h7F, 0); gap();
        check("t4_skip_cnt", ev_cnt, 4);
        send(8'h90, 0); send(8'h3C, 0); send(8'h64, 0); gap();
        check_ev("t4", 5, 1'b1, 4'h0, 7'h3C, 7'h64, 8'hBC);

        // Framing error on the velocity byte
        send(8'h90, 0); send(8'h3C, 0); send(8'h64, 1); gap();
        check("t5_err_cnt", ev_cnt, 5);
        check("t5_err", err, 8'h01);
        send(8'h3C, 0); send(8'h64, 0); gap();
        check_ev("t5", 6, 1'b1, 4'h0, 7'h3C, 7'h64, 8'hBC);

        // Program change with running status skipped
        send(8'hC0, 0); send(8'h05, 0); send(8'h06, 0); gap();
        check("t6_skip_cnt", ev_cnt, 6);
        send(8'h91, 0); send(8'h41, 0); send(8'h22, 0); gap();
        check_ev("t6", 7, 1'b1, 4'h1, 7'h41, 7'h22, 8'hC1);

        // Sysex dump, then data in IDLE discarded
        send(8'hF0, 0); send(8'h01, 0); send(8'h02, 0); send(8'hF7, 0);
        send(8'h40, 0); send(8'h22, 0); gap();
        check("t7_sysex_cnt", ev_cnt, 7);
        // Note-off for a note not held leaves LED
        send(8'h80, 0); send(8'h3C, 0); send(8'h10, 0); gap();
        check_ev("t7a", 8, 1'b0, 4'h0, 7'h3C, 7'h10, 8'hC1);
        send(8'h81, 0); send(8'h41, 0); send(8'h00, 0); gap();
        check_ev("t7b", 9, 1'b0, 4'h1, 7'h41, 7'h00, 8'h00);

        // Channel filter on the non-omni instance
        check("t8_ch_pre_cnt", ev_cnt2, 0);
        check("t8_ch_pre_led", led2, 8'h00);
        send(8'h92, 0); send(8'h50, 0); send(8'h60, 0); gap();
        check_ev("t8", 10, 1'b1, 4'h2, 7'h50, 7'h60, 8'hD0);
        check("t8_ch_cnt", ev_cnt2, 1);
        check("t8_ch_chan", bus2.EV_CHAN, 4'h2);
        check("t8_ch_led", led2, 8'hD0);

        // Reset mid-message: asynchronous clear, partial message discarded
        send(8'h90, 0); send(8'h3C, 0); gap();
        #2 rst_n = 1'b0;
        #1;
        check("t9_rst_valid", bus.EV_VALID, 1'b0);
        check("t9_rst_on", bus.EV_NOTE_ON, 1'b0);
        check("t9_rst_chan", bus.EV_CHAN, 4'h0);
        check("t9_rst_note", bus.EV_NOTE, 7'h00);
        check("t9_rst_vel", bus.EV_VEL, 7'h00);
        check("t9_rst_led", led, 8'h00);
        check("t9_rst_err", err, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h64, 0); gap();
        check_ev("t9_after", 10, 1'b0, 4'h0, 7'h00, 7'h00, 8'h00);
        send(8'h90, 0); send(8'h3C, 0); send(8'h64, 0); gap();
        check_ev("t9_first", 11, 1'b1, 4'h0, 7'h3C, 7'h64, 8'hBC);

        // Error counter saturation with back-to-back strobes
        for (int i = 0; i < 300; i++) send(8'h55, 1);
        gap();
        check("t10_err_sat", err, 8'hFF);
        check("t10_cnt", ev_cnt, 11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
